// File: rtl/mux_arbiter4.sv
// mux_arbiter4: four-requester round-robin arbiter driving a shared 4-to-1
// mux. The selected word is captured into a single-entry output register and
// handed downstream with a valid/ready handshake.
//
// Build option: define ARB_BURST_LOCK_EN to keep a grant for up to MAX_BURST
// back-to-back beats. Without it every grant carries exactly one beat.
module mux_arbiter4 #(
   parameter int WIDTH     = 8,
   parameter int MAX_BURST = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [3:0]         req,
   input  logic [4*WIDTH-1:0] din,
   output logic [3:0]         ack,
   output logic [1:0]         sel,
   output logic [WIDTH-1:0]   dout,
   output logic               dout_valid,
   input  logic               dout_ready,
   output logic               busy
);

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] GRANT = 1'b1;

   logic [0:0]       state;
   logic [1:0]       ptr;       // last source that completed a grant
   logic [1:0]       winner;
   logic [1:0]       cand;
   logic [WIDTH-1:0] sel_data;
   logic             slot_free;
   logic             xfer;

`ifdef ARB_BURST_LOCK_EN
   logic [3:0]       beats;     // beats already moved in the current grant
`else
   // Single-beat build: MAX_BURST stays in the parameter list so both builds
   // share one instantiation template.
   localparam int unused_max_burst = MAX_BURST;
`endif

   // Round-robin pick: first requester after ptr, wrapping, ptr itself last.
   always_comb begin
      // NOTE: every variable gets a default before any conditional assignment so no latch is inferred.
      winner = ptr + 2'd1;
      cand   = ptr;
      // Walk the candidates from farthest to nearest so the nearest one wins.
      for (int k = 4; k >= 1; k--) begin
         cand = ptr + 2'(k);
         if (req[cand]) winner = cand;
      end
   end

   // Mux the granted source onto the capture path.
   always_comb begin
      sel_data = '0;
      for (int i = 0; i < 4; i++) begin
         if (sel == 2'(i)) sel_data = din[i*WIDTH +: WIDTH];
      end
   end

   // A beat moves when the granted source still requests and the output slot
   // is empty or being drained this cycle.
   always_comb begin
      slot_free = !dout_valid || dout_ready;
      xfer      = (state == GRANT) && req[sel] && slot_free;
      ack       = xfer ? (4'b0001 << sel) : 4'b0000;
      busy      = (state == GRANT);
   end

   // Grant sequencing: arbitrate in IDLE, hold the mux select through GRANT.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
      if (rst) begin
         state <= IDLE;
         ptr   <= 2'd3;
         sel   <= 2'd0;
      end else begin
         case (state)
            IDLE: begin
               if (|req) begin
                  sel   <= winner;
                  state <= GRANT;
               end
            end
            GRANT: begin
`ifdef ARB_BURST_LOCK_EN
               if (xfer) begin
                  if (beats + 4'd1 >= 4'(MAX_BURST)) begin
                     ptr   <= sel;
                     state <= IDLE;
                  end
               end else if (!req[sel]) begin
                  // Ending a burst early still rotates priority; a grant that
                  // never moved a beat leaves the pointer alone.
                  if (beats != 4'd0) ptr <= sel;
                  state <= IDLE;
               end
`else
               if (xfer) begin
                  ptr   <= sel;
                  state <= IDLE;
               end else if (!req[sel]) begin
                  state <= IDLE;
               end
`endif
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef ARB_BURST_LOCK_EN
   // Beat counter for the current grant; held at zero while idle.
   always_ff @(posedge clk) begin
      if (rst || state == IDLE) beats <= 4'd0;
      else if (xfer)            beats <= beats + 4'd1;
   end
`endif

   // Single-entry output register: capture wins over drain in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         dout       <= '0;
         dout_valid <= 1'b0;
      end else if (xfer) begin
         dout       <= sel_data;
         dout_valid <= 1'b1;
      end else if (dout_ready) begin
         dout_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mux_arbiter4.sv
// Testbench for mux_arbiter4: directed scenarios plus randomized traffic
// checked against a transaction-level model of the round-robin rules.
module tb_mux_arbiter4;

   localparam int WIDTH     = 8;
   localparam int MAX_BURST = 4;
`ifdef ARB_BURST_LOCK_EN
   localparam bit BURST = 1'b1;
`else
   localparam bit BURST = 1'b0;
`endif
   localparam int BEATS_PER_GRANT = BURST ? MAX_BURST : 1;
   localparam int GRANT_GAP       = BEATS_PER_GRANT + 1;

   logic             clk = 1'b0;
   logic             rst;
   logic [3:0]       req;
   logic [31:0]      din;
   logic [3:0]       ack;
   logic [1:0]       sel;
   logic [WIDTH-1:0] dout;
   logic             dout_valid;
   logic             dout_ready;
   logic             busy;

   int n_checks = 0;
   int n_fail   = 0;

   mux_arbiter4 #(.WIDTH(WIDTH), .MAX_BURST(MAX_BURST)) dut (
      .clk(clk), .rst(rst), .req(req), .din(din), .ack(ack), .sel(sel),
      .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready), .busy(busy)
   );

   always #5 clk = ~clk;

   // Reference model: granted source (-1 = none), priority pointer, output slot.
   int         m_gnt   = -1;
   int         m_ptr   = 3;
   int         m_sel   = 0;
   int         m_beats = 0;
   logic [7:0] m_dout  = 8'h00;
   logic       m_valid = 1'b0;
   logic [3:0] e_ack;
   logic       e_busy;

   // Advance the model by one clock using the inputs held during that clock.
   task automatic model_commit();
      if (rst) begin
         m_gnt = -1; m_ptr = 3; m_sel = 0; m_beats = 0;
         m_dout = 8'h00; m_valid = 1'b0;
      end else if (m_gnt < 0) begin
         if (dout_ready) m_valid = 1'b0;
         for (int k = 1; k <= 4; k++) begin
            int s;
            s = (m_ptr + k) % 4;
            if (m_gnt < 0 && req[s]) begin
               m_gnt = s; m_sel = s; m_beats = 0;
            end
         end
      end else if (req[m_gnt] && (!m_valid || dout_ready)) begin
         m_dout  = din[m_gnt*8 +: 8];
         m_valid = 1'b1;
         m_beats++;
         if (m_beats >= BEATS_PER_GRANT) begin
            m_ptr = m_gnt; m_gnt = -1;
         end
      end else begin
         if (dout_ready) m_valid = 1'b0;
         if (!req[m_gnt]) begin
            if (m_beats > 0) m_ptr = m_gnt;
            m_gnt = -1;
         end
      end
   endtask

   // One cycle: commit the model, apply new inputs after the falling edge,
   // then derive the expected combinational outputs.
   task automatic step(input logic r, input logic [3:0] rq, input logic [31:0] d, input logic rd);
      model_commit();
      @(negedge clk);
      rst = r; req = rq; din = d; dout_ready = rd;
      #1;
      e_busy = (m_gnt >= 0);
      e_ack  = 4'b0000;
      if (m_gnt >= 0 && req[m_gnt] && (!m_valid || dout_ready)) e_ack[m_gnt] = 1'b1;
   endtask

   task automatic do_reset();
      step(1'b1, 4'b0000, 32'h0, 1'b1);
   endtask

   task automatic test_reset();
      step(1'b1, 4'b1111, $urandom, 1'b1);
      step(1'b1, 4'b1111, $urandom, 1'b1);
      n_checks++; if (sel !== 2'd0) begin n_fail++; $display("FAIL reset_sel: got %0d want 0", sel); end
      n_checks++; if (ack !== 4'b0000) begin n_fail++; $display("FAIL reset_ack: got %b want 0000", ack); end
      n_checks++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", dout_valid); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_checks++; if (dout !== 8'h00) begin n_fail++; $display("FAIL reset_dout: got %h want 00", dout); end
      step(1'b0, 4'b1111, $urandom, 1'b1);
      n_checks++; if (busy !== 1'b0 || ack !== 4'b0000) begin n_fail++; $display("FAIL reset_idle: busy=%b ack=%b want 0/0000", busy, ack); end
      step(1'b0, 4'b1111, $urandom, 1'b1);
      n_checks++; if (busy !== 1'b1 || sel !== 2'd0) begin n_fail++; $display("FAIL reset_first_grant: busy=%b sel=%0d want 1/0", busy, sel); end
      n_checks++; if (ack !== 4'b0001) begin n_fail++; $display("FAIL reset_first_ack: got %b want 0001", ack); end
      step(1'b0, 4'b0000, 32'h0, 1'b1);
   endtask

   task automatic test_single();
      do_reset();
      step(1'b0, 4'b0100, 32'h00A5_0000, 1'b1);
      n_checks++; if (ack !== 4'b0000) begin n_fail++; $display("FAIL single_c0_ack: got %b want 0000", ack); end
      step(1'b0, 4'b0100, 32'h00A5_0000, 1'b1);
      n_checks++; if (sel !== 2'd2) begin n_fail++; $display("FAIL single_sel: got %0d want 2", sel); end
      n_checks++; if (ack !== 4'b0100) begin n_fail++; $display("FAIL single_ack: got %b want 0100", ack); end
      step(1'b0, 4'b0000, 32'h0, 1'b1);
      n_checks++; if (dout !== 8'hA5 || dout_valid !== 1'b1) begin n_fail++; $display("FAIL single_dout: got %h/%b want a5/1", dout, dout_valid); end
      step(1'b0, 4'b0000, 32'h0, 1'b1);
   endtask

   task automatic test_round_robin();
      int   starts[$];
      int   start_cyc[$];
      logic prev_busy;
      prev_busy = 1'b0;
      do_reset();
      for (int c = 0; c < 80 && starts.size() < 5; c++) begin
         step(1'b0, 4'b1111, $urandom, 1'b1);
         n_checks++; if (ack !== e_ack) begin n_fail++; $display("FAIL rr_ack: cycle %0d got %b want %b", c, ack, e_ack); end
         if (busy === 1'b1 && prev_busy === 1'b0) begin
            starts.push_back(int'(sel));
            start_cyc.push_back(c);
         end
         prev_busy = busy;
      end
      n_checks++;
      if (starts.size() != 5) begin
         n_fail++; $display("FAIL rr_grant_count: got %0d want 5", starts.size());
      end else begin
         for (int i = 0; i < 5; i++) begin
            n_checks++; if (starts[i] != i % 4) begin n_fail++; $display("FAIL rr_order: grant %0d got %0d want %0d", i, starts[i], i % 4); end
            if (i > 0) begin
               n_checks++; if (start_cyc[i] - start_cyc[i-1] != GRANT_GAP) begin
                  n_fail++; $display("FAIL rr_gap: grant %0d got %0d want %0d", i, start_cyc[i] - start_cyc[i-1], GRANT_GAP);
               end
            end
         end
      end
      step(1'b1, 4'b0000, 32'h0, 1'b1);
   endtask

   task automatic test_backpressure();
      bit found;
      int acks;
      do_reset();
      step(1'b0, 4'b0001, 32'h0000_0011, 1'b0);
      step(1'b0, 4'b0001, 32'h0000_0011, 1'b0);
      n_checks++; if (ack !== 4'b0001) begin n_fail++; $display("FAIL bp_fill_ack: got %b want 0001", ack); end
      found = 1'b0;
      for (int c = 0; c < 6 && !found; c++) begin
         step(1'b0, 4'b0010, 32'h0000_5500, 1'b0);
         n_checks++; if (ack !== e_ack) begin n_fail++; $display("FAIL bp_wait_ack: got %b want %b", ack, e_ack); end
         if (busy === 1'b1 && sel === 2'd1) found = 1'b1;
      end
      n_checks++; if (!found) begin n_fail++; $display("FAIL bp_grant_timeout: busy=%b sel=%0d want 1/1", busy, sel); end
      acks = 0;
      for (int c = 0; c < 3; c++) begin
         step(1'b0, 4'b0010, 32'h0000_5500, 1'b0);
         if (ack != 4'b0000) acks++;
         n_checks++; if (busy !== 1'b1 || sel !== 2'd1) begin n_fail++; $display("FAIL bp_stall_hold: busy=%b sel=%0d want 1/1", busy, sel); end
         n_checks++; if (dout_valid !== 1'b1 || dout !== 8'h11) begin n_fail++; $display("FAIL bp_stall_data: got %h/%b want 11/1", dout, dout_valid); end
      end
      n_checks++; if (acks != 0) begin n_fail++; $display("FAIL bp_stall_ack: got %0d acks want 0", acks); end
      step(1'b0, 4'b0010, 32'h0000_5500, 1'b1);
      n_checks++; if (ack !== 4'b0010) begin n_fail++; $display("FAIL bp_release_ack: got %b want 0010", ack); end
      step(1'b0, 4'b0000, 32'h0, 1'b0);
      n_checks++; if (dout !== 8'h55 || dout_valid !== 1'b1) begin n_fail++; $display("FAIL bp_new_word: got %h/%b want 55/1", dout, dout_valid); end
      n_checks++; if (ack !== 4'b0000) begin n_fail++; $display("FAIL bp_no_dup_ack: got %b want 0000", ack); end
   endtask

   task automatic test_abandon();
      bit found;
      do_reset();
      step(1'b0, 4'b1000, 32'h3300_0000, 1'b0);
      step(1'b0, 4'b1000, 32'h3300_0000, 1'b0);
      n_checks++; if (ack !== 4'b1000) begin n_fail++; $display("FAIL ab_fill_ack: got %b want 1000", ack); end
      step(1'b0, 4'b0000, 32'h0, 1'b0);
      found = 1'b0;
      for (int c = 0; c < 6 && !found; c++) begin
         step(1'b0, 4'b1000, 32'h7700_0000, 1'b0);
         n_checks++; if (ack !== 4'b0000) begin n_fail++; $display("FAIL ab_stall_ack: got %b want 0000", ack); end
         if (busy === 1'b1 && sel === 2'd3) found = 1'b1;
      end
      n_checks++; if (!found) begin n_fail++; $display("FAIL ab_grant_timeout: busy=%b sel=%0d want 1/3", busy, sel); end
      step(1'b0, 4'b0000, 32'h0, 1'b0);
      n_checks++; if (ack !== 4'b0000) begin n_fail++; $display("FAIL ab_drop_ack: got %b want 0000", ack); end
      step(1'b0, 4'b1001, 32'h7700_0044, 1'b1);
      n_checks++; if (busy !== 1'b0 || ack !== 4'b0000) begin n_fail++; $display("FAIL ab_idle: busy=%b ack=%b want 0/0000", busy, ack); end
      n_checks++; if (dout !== 8'h33 || dout_valid !== 1'b1) begin n_fail++; $display("FAIL ab_kept_word: got %h/%b want 33/1", dout, dout_valid); end
      step(1'b0, 4'b1001, 32'h7700_0044, 1'b1);
      n_checks++; if (busy !== 1'b1 || sel !== 2'd0) begin n_fail++; $display("FAIL ab_next_grant: busy=%b sel=%0d want 1/0", busy, sel); end
      n_checks++; if (ack !== 4'b0001) begin n_fail++; $display("FAIL ab_next_ack: got %b want 0001", ack); end
      step(1'b0, 4'b0000, 32'h0, 1'b1);
   endtask

   task automatic test_burst();
      int count;
      do_reset();
      count = 0;
      for (int c = 0; c < 30 && count < BEATS_PER_GRANT; c++) begin
         step(1'b0, 4'b0010, $urandom, 1'b1);
         n_checks++; if (ack !== e_ack) begin n_fail++; $display("FAIL burst_ack: cycle %0d got %b want %b", c, ack, e_ack); end
         n_checks++; if (dout !== m_dout || dout_valid !== m_valid) begin
            n_fail++; $display("FAIL burst_data: got %h/%b want %h/%b", dout, dout_valid, m_dout, m_valid);
         end
         if (ack[1] === 1'b1) count++;
      end
      n_checks++; if (count != BEATS_PER_GRANT) begin n_fail++; $display("FAIL burst_beats: got %0d want %0d", count, BEATS_PER_GRANT); end
      step(1'b0, 4'b1111, $urandom, 1'b1);
      n_checks++; if (busy !== 1'b0 || ack !== 4'b0000) begin n_fail++; $display("FAIL burst_end_idle: busy=%b ack=%b want 0/0000", busy, ack); end
      step(1'b0, 4'b1111, $urandom, 1'b1);
      n_checks++; if (busy !== 1'b1 || sel !== 2'd2) begin n_fail++; $display("FAIL burst_ptr: busy=%b sel=%0d want 1/2", busy, sel); end
      step(1'b1, 4'b0000, 32'h0, 1'b1);
   endtask

   task automatic test_random();
      logic [3:0] nreq;
      logic       nrst;
      do_reset();
      nreq = 4'b0000;
      for (int c = 0; c < 600; c++) begin
         nrst = ($urandom_range(0, 60) == 0);
         step(nrst, nreq, $urandom, 1'($urandom_range(0, 3) != 0));
         n_checks++; if (ack !== e_ack) begin n_fail++; $display("FAIL rand_ack: cycle %0d got %b want %b", c, ack, e_ack); end
         n_checks++; if (busy !== e_busy) begin n_fail++; $display("FAIL rand_busy: cycle %0d got %b want %b", c, busy, e_busy); end
         n_checks++; if (dout_valid !== m_valid) begin n_fail++; $display("FAIL rand_valid: cycle %0d got %b want %b", c, dout_valid, m_valid); end
         n_checks++; if (dout !== m_dout) begin n_fail++; $display("FAIL rand_dout: cycle %0d got %h want %h", c, dout, m_dout); end
         n_checks++; if (int'(sel) != m_sel) begin n_fail++; $display("FAIL rand_sel: cycle %0d got %0d want %0d", c, sel, m_sel); end
         n_checks++; if (!$onehot0(ack)) begin n_fail++; $display("FAIL rand_onehot: cycle %0d got %b", c, ack); end
         // A source keeps requesting until acked, then chooses again at random.
         for (int i = 0; i < 4; i++) begin
            if (!req[i] || e_ack[i]) nreq[i] = 1'($urandom_range(0, 1));
         end
      end
   endtask

   initial begin
      rst = 1'b1; req = 4'b0000; din = 32'h0; dout_ready = 1'b1;
      test_reset();
      test_single();
      test_round_robin();
      test_backpressure();
      test_abandon();
      test_burst();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
